// File: rtl/cory_pkg.sv
// Shared definitions for the cory_skid buffer: state encoding of the
// two-entry skid controller.
package cory_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage : cory_pkg

// File: rtl/cory_skid_ent.sv
// One N-bit storage entry of the skid buffer: load-enabled register with
// asynchronous active-high clear.
module cory_skid_ent #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : cory_skid_ent

// File: rtl/cory_skid.sv
// Two-entry skid buffer (main + skid) with registered upstream ready.
// Optional zero-latency EMPTY bypass enabled by defining CORY_SKID_BYPASS_EN.
module cory_skid
  import cory_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_a_v,
  input  logic [N-1:0] i_a_d,
  output logic         o_a_r,
  output logic [N-1:0] o_z_d,
  output logic         o_z_v,
  input  logic         i_z_r
);

  // A zero-width data path is meaningless; stop elaboration in simulation.
  if (N == 0) begin : g_bad_width
    $fatal(1, "cory_skid: parameter N must be at least 1");
  end

  state_e       state_q, state_d;
  logic         a_r_q;
  logic         z_v_q;
  logic         main_en, skid_en, main_from_skid;
  logic [N-1:0] main_d, main_q, skid_q;
  logic         up_xfer, dn_xfer;

  assign up_xfer = i_a_v & a_r_q;
  assign dn_xfer = o_z_v & i_z_r;

  // Next-state and entry load selection.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
`ifdef CORY_SKID_BYPASS_EN
        if (up_xfer && !i_z_r) begin
          main_en = 1'b1;
          state_d = ONE;
        end
`else
        if (up_xfer) begin
          main_en = 1'b1;
          state_d = ONE;
        end
`endif
      end
      ONE: begin
        if (up_xfer && dn_xfer) begin
          main_en = 1'b1;
        end else if (up_xfer) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (dn_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (dn_xfer) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign main_d = main_from_skid ? skid_q : i_a_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      a_r_q   <= 1'b1;
      z_v_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_r_q   <= (state_d != FULL);
      z_v_q   <= (state_d != EMPTY);
    end
  end

  cory_skid_ent #(.N(N)) u_main (
    .clk   (clk),
    .reset (reset),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  cory_skid_ent #(.N(N)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en_i  (skid_en),
    .d_i   (i_a_d),
    .q_o   (skid_q)
  );

  assign o_a_r = a_r_q;

`ifdef CORY_SKID_BYPASS_EN
  // In EMPTY the upstream beat is presented straight to the output.
  assign o_z_v = z_v_q | ((state_q == EMPTY) & i_a_v & ~reset);
  assign o_z_d = (state_q == EMPTY) ? i_a_d : main_q;
`else
  assign o_z_v = z_v_q;
  assign o_z_d = main_q;
`endif

endmodule : cory_skid

// File: tb/tb_cory_skid.sv
// Self-checking bench for cory_skid: directed phases plus a random-stall
// phase, with a data scoreboard checked by an independent output monitor.
module tb_cory_skid;

  localparam int unsigned N = 8;

  logic         clk;
  logic         reset;
  logic         i_a_v;
  logic [N-1:0] i_a_d;
  logic         o_a_r;
  logic [N-1:0] o_z_d;
  logic         o_z_v;
  logic         i_z_r;

  int unsigned  n_checks;
  int unsigned  n_pass;
  logic [N-1:0] exp_q[$];

  cory_skid #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .i_a_v (i_a_v),
    .i_a_d (i_a_d),
    .o_a_r (o_a_r),
    .o_z_d (o_z_d),
    .o_z_v (o_z_v),
    .i_z_r (i_z_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs change and registered outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a downstream transfer happens at the next posedge when valid & ready.
  always @(negedge clk) begin
    if (!reset && o_z_v && i_z_r) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got %0h expected none", o_z_d);
      end else begin
        chk("scoreboard_data", 32'(o_z_d), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] stream_d;
    logic         ar_before;
    int           guard;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    i_a_v    = 1'b0;
    i_a_d    = 8'h5A;
    i_z_r    = 1'b0;

    // Reset values, held regardless of clock.
    #3;
    chk("rst_z_v", 32'(o_z_v), 32'd0);
    chk("rst_z_d", 32'(o_z_d), 32'd0);
    chk("rst_a_r", 32'(o_a_r), 32'd1);
    repeat (3) step();
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_z_v", 32'(o_z_v), 32'd0);
      chk("idle_z_d", 32'(o_z_d), 32'd0);
      chk("idle_a_r", 32'(o_a_r), 32'd1);
    end

    // Streaming 0x01..0x10 with the sink always ready.
    for (int k = 1; k <= 16; k++) begin
      stream_d = 8'(k);
      exp_q.push_back(stream_d);
    end
    i_z_r = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      i_a_v = 1'b1;
      i_a_d = 8'(k);
      step();
      chk("stream_z_v", 32'(o_z_v), 32'd1);
      chk("stream_z_d", 32'(o_z_d), 32'(k));
      chk("stream_a_r", 32'(o_a_r), 32'd1);
    end
    i_a_v = 1'b0;
    step();
    chk("stream_end_z_v", 32'(o_z_v), 32'd0);

    // Backpressure fill: A1, A2 stored, A3 held upstream.
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    i_z_r = 1'b0;
    i_a_v = 1'b1;
    i_a_d = 8'hA1;
    step();
    chk("bp1_a_r", 32'(o_a_r), 32'd1);
    chk("bp1_z_d", 32'(o_z_d), 32'hA1);
    i_a_d = 8'hA2;
    step();
    chk("bp2_a_r", 32'(o_a_r), 32'd0);
    chk("bp2_z_d", 32'(o_z_d), 32'hA1);
    i_a_d = 8'hA3;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp3_a_r", 32'(o_a_r), 32'd0);
      chk("bp3_z_v", 32'(o_z_v), 32'd1);
      chk("bp3_z_d", 32'(o_z_d), 32'hA1);
    end

    // Drain from FULL, A3 accepted once ready returns.
    i_z_r = 1'b1;
    step();
    chk("drain1_a_r", 32'(o_a_r), 32'd1);
    chk("drain1_z_d", 32'(o_z_d), 32'hA2);
    step();
    chk("drain2_z_d", 32'(o_z_d), 32'hA3);
    i_a_v = 1'b0;
    step();
    chk("drain3_z_v", 32'(o_z_v), 32'd0);

    // Mid-operation reset with B1/B2 stored; they must be discarded.
    i_z_r = 1'b0;
    i_a_v = 1'b1;
    i_a_d = 8'hB1;
    step();
    i_a_d = 8'hB2;
    step();
    chk("mid_full_a_r", 32'(o_a_r), 32'd0);
    i_a_v = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_z_v", 32'(o_z_v), 32'd0);
    chk("mid_rst_z_d", 32'(o_z_d), 32'd0);
    chk("mid_rst_a_r", 32'(o_a_r), 32'd1);
    step();
    step();
    reset = 1'b0;
    exp_q.push_back(8'hC1);
    i_z_r = 1'b1;
    i_a_v = 1'b1;
    i_a_d = 8'hC1;
    step();
    chk("post_rst_z_v", 32'(o_z_v), 32'd1);
    chk("post_rst_z_d", 32'(o_z_d), 32'hC1);
    i_a_v = 1'b0;
    step();
    chk("post_rst_idle", 32'(o_z_v), 32'd0);

    // Random stalls; o_a_r must not react to same-cycle input changes.
    for (int c = 0; c < 2000; c++) begin
      ar_before = o_a_r;
      i_a_v = 1'($urandom_range(1, 0));
      i_a_d = 8'($urandom);
      i_z_r = 1'($urandom_range(1, 0));
      #1;
      chk("rand_a_r_stable", 32'(o_a_r), 32'(ar_before));
      if (i_a_v && o_a_r) exp_q.push_back(i_a_d);
      step();
    end

    // Drain whatever remains, bounded.
    i_a_v = 1'b0;
    i_z_r = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    step();
    chk("final_z_v", 32'(o_z_v), 32'd0);
    chk("final_a_r", 32'(o_a_r), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cory_skid
